// File: rtl/v_red_pkg.sv
// v_red_pkg: shared constants and helpers for the reduction issue front-end.
package v_red_pkg;
    localparam logic [1:0] OPSEL_AND = 2'b01;
    localparam logic [1:0] OPSEL_OR  = 2'b10;
    localparam logic [1:0] OPSEL_XOR = 2'b11;
    localparam logic [1:0] SEW_8  = 2'd0;
    localparam logic [1:0] SEW_16 = 2'd1;
    localparam logic [1:0] SEW_32 = 2'd2;
    localparam logic [1:0] SEW_64 = 2'd3;

    typedef enum logic {IDLE, READ} state_t;

    function automatic logic [7:0] red_identity(input logic [1:0] op_sel);
        return op_sel == OPSEL_AND ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [3:0] sew_bytes(input logic [1:0] sew);
        return sew == SEW_8 ? 4'd1 : sew == SEW_16 ? 4'd2 : sew == SEW_32 ? 4'd4 : 4'd8;
    endfunction
endpackage

// File: rtl/v_red_tail_fill.sv
// v_red_tail_fill: replaces inactive bytes of a beat with the op identity byte.
module v_red_tail_fill
    import v_red_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int OPSEL_WIDTH = 2,
    parameter int SEW_WIDTH   = 2
) (
    input  logic [DATA_WIDTH-1:0]  word,
    input  logic [2:0]             tb,
    input  logic                   is_last,
    input  logic                   is_scalar,
    input  logic [SEW_WIDTH-1:0]   sew,
    input  logic [OPSEL_WIDTH-1:0] op_sel,
    output logic [DATA_WIDTH-1:0]  filled
);
    logic [3:0] eb;
    logic [7:0] id;

    assign eb = sew_bytes(sew);
    assign id = red_identity(op_sel);

    // scalar beat keeps only lane 0; last data beat keeps only bytes below tb
    for (genvar i = 0; i < DATA_WIDTH / 8; i++) begin : g_byte
        assign filled[i*8 +: 8] = (is_scalar ? 4'(i) >= eb
                                             : is_last && tb != 3'd0 && 4'(i) >= {1'b0, tb})
                                  ? id : word[i*8 +: 8];
    end
endmodule

// File: rtl/v_red_issue.sv
// v_red_issue: sequences one AND/OR/XOR reduction into a gap-free beat train:
// scalar beat first, then vs2 words read from the VRF with tail bytes filled.
module v_red_issue
    import v_red_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int VL_WIDTH    = 11,
    parameter int OPSEL_WIDTH = 2,
    parameter int SEW_WIDTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [OPSEL_WIDTH-1:0] req_opSel,
    input  logic [SEW_WIDTH-1:0]   req_sew,
    input  logic [VL_WIDTH-1:0]    req_vl,
    input  logic [ADDR_WIDTH-1:0]  req_vs2_addr,
    input  logic [ADDR_WIDTH-1:0]  req_vd_addr,
    input  logic [DATA_WIDTH-1:0]  req_scalar,
    output logic                   vrf_rd_en,
    output logic [ADDR_WIDTH-1:0]  vrf_rd_addr,
    input  logic [DATA_WIDTH-1:0]  vrf_rd_data,
    output logic [DATA_WIDTH-1:0]  out_vec0,
    output logic [DATA_WIDTH-1:0]  out_vec1,
    output logic                   out_valid,
    output logic                   out_start,
    output logic                   out_end,
    output logic [OPSEL_WIDTH-1:0] out_opSel,
    output logic [SEW_WIDTH-1:0]   out_sew,
    output logic [ADDR_WIDTH-1:0]  out_addr
);
    localparam int CW = VL_WIDTH + 3;

    state_t                 state, state_d;
    logic [CW-1:0]          req_bytes, req_words, n_q, cnt;
    logic [OPSEL_WIDTH-1:0] op_q;
    logic [SEW_WIDTH-1:0]   sew_q;
    logic [2:0]             tb_q;
    logic [ADDR_WIDTH-1:0]  vd_q;
    logic [DATA_WIDTH-1:0]  scalar_q, filled;
    logic                   accept, start_train, sc_q, tag_v, tag_last, beat;

    assign req_ready   = state == IDLE;
    assign accept      = req_valid && req_ready;
    assign start_train = accept && req_vl != '0;
    assign req_bytes   = CW'(req_vl) << req_sew;
    assign req_words   = (req_bytes + CW'(7)) >> 3;
    assign beat        = sc_q || tag_v;
    assign out_vec1    = '0;

    always_comb begin
        state_d = state;
        state_d = state == IDLE ? (start_train ? READ : IDLE) : (cnt == n_q ? IDLE : READ);
    end

    // scalar beat and read returns never coincide, so one fill unit serves both
    v_red_tail_fill #(
        .DATA_WIDTH (DATA_WIDTH),
        .OPSEL_WIDTH(OPSEL_WIDTH),
        .SEW_WIDTH  (SEW_WIDTH)
    ) u_fill (
        .word     (sc_q ? scalar_q : vrf_rd_data),
        .tb       (tb_q),
        .is_last  (tag_last),
        .is_scalar(sc_q),
        .sew      (sew_q),
        .op_sel   (op_q),
        .filled   (filled)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            n_q         <= '0;
            cnt         <= '0;
            op_q        <= '0;
            sew_q       <= '0;
            tb_q        <= '0;
            vd_q        <= '0;
            scalar_q    <= '0;
            sc_q        <= 1'b0;
            tag_v       <= 1'b0;
            tag_last    <= 1'b0;
            vrf_rd_en   <= 1'b0;
            vrf_rd_addr <= '0;
            out_vec0    <= '0;
            out_valid   <= 1'b0;
            out_start   <= 1'b0;
            out_end     <= 1'b0;
            out_opSel   <= '0;
            out_sew     <= '0;
            out_addr    <= '0;
        end else begin
            state    <= state_d;
            sc_q     <= start_train;
            tag_v    <= vrf_rd_en;
            tag_last <= vrf_rd_en && cnt == n_q;
            if (accept) begin
                op_q     <= req_opSel;
                sew_q    <= req_sew;
                tb_q     <= req_bytes[2:0];
                n_q      <= req_words;
                vd_q     <= req_vd_addr;
                scalar_q <= req_scalar;
            end
            if (start_train) begin
                vrf_rd_en   <= 1'b1;
                vrf_rd_addr <= req_vs2_addr;
                cnt         <= CW'(1);
            end else if (state == READ && cnt != n_q) begin
                vrf_rd_en   <= 1'b1;
                vrf_rd_addr <= vrf_rd_addr + ADDR_WIDTH'(1);
                cnt         <= cnt + CW'(1);
            end else begin
                vrf_rd_en   <= 1'b0;
                vrf_rd_addr <= '0;
            end
            out_valid <= beat;
            out_start <= sc_q;
            out_end   <= tag_v && tag_last;
            out_vec0  <= beat ? filled : '0;
            out_opSel <= beat ? op_q : '0;
            out_sew   <= beat ? sew_q : '0;
            out_addr  <= beat ? vd_q : '0;
        end
    end
endmodule
